// File: rtl/gfx_pkg.sv
// gfx_pkg -- definitions shared by the graphics datapath blocks.
//
// Contents:
//   wr_bridge_state_t  : state encoding of the SDRAM write-burst bridge
//   PIXEL_W            : pixel width (RGB565)
//   BANK_*             : position of the SDRAM bank field inside a word
//                        address laid out as {bank[1:0], row, col}. The
//                        drawing primitives use these too.
package gfx_pkg;

  localparam int PIXEL_W   = 16;
  localparam int ADDR_W    = 24;
  localparam int COL_W     = 9;

  // Bank field sits in the top two address bits.
  localparam int BANK_W    = 2;
  localparam int BANK_LSB  = ADDR_W - BANK_W;
  localparam int BANK_MSB  = ADDR_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_DATA      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FIN       = 3'd4
  } wr_bridge_state_t;

endpackage

// File: rtl/wr_burst_bridge_if.sv
// wr_burst_bridge_if -- SDRAM controller write port.
//
// Signals:
//   sdram_wr_req       bridge -> ctrl  burst request
//   sdram_wr_addr      bridge -> ctrl  burst start word address
//   sdram_wr_len       bridge -> ctrl  burst length in words
//   sdram_wr_ack       ctrl -> bridge  request accepted
//   sdram_wr_data_req  ctrl -> bridge  one data word wanted this cycle
//   sdram_wr_data      bridge -> ctrl  data word (same cycle as data_req)
//   sdram_wr_done      ctrl -> bridge  burst finished
// Modports: master = bridge side, slave = controller side.
interface wr_burst_bridge_if
  import gfx_pkg::*;
#(
  parameter int ADDR_BITS  = ADDR_W,
  parameter int BURST_BITS = 10,
  parameter int DATA_BITS  = PIXEL_W
);

  logic                  sdram_wr_req;
  logic [ADDR_BITS-1:0]  sdram_wr_addr;
  logic [BURST_BITS-1:0] sdram_wr_len;
  logic                  sdram_wr_ack;
  logic                  sdram_wr_data_req;
  logic [DATA_BITS-1:0]  sdram_wr_data;
  logic                  sdram_wr_done;

  modport master (
    output sdram_wr_req, sdram_wr_addr, sdram_wr_len, sdram_wr_data,
    input  sdram_wr_ack, sdram_wr_data_req, sdram_wr_done
  );

  modport slave (
    input  sdram_wr_req, sdram_wr_addr, sdram_wr_len, sdram_wr_data,
    output sdram_wr_ack, sdram_wr_data_req, sdram_wr_done
  );

endinterface

// File: rtl/burst_len_clip.sv
// burst_len_clip -- effective burst length: the smallest of the requested
// length, MAX_BURST_LEN and the words left in the current SDRAM page.
// Purely combinational; shared with the read bridge.
//
// Ports:
//   req_len  in   requested length
//   col      in   column part of the start address
//   len_eff  out  clipped length (always <= MAX_BURST_LEN)
module burst_len_clip #(
  parameter int BURST_BITS    = 10,
  parameter int COL_BITS      = 9,
  parameter int MAX_BURST_LEN = 128
) (
  input  logic [BURST_BITS-1:0] req_len,
  input  logic [COL_BITS-1:0]   col,
  output logic [BURST_BITS-1:0] len_eff
);

  // One extra bit so a full page (2^COL_BITS) is representable when col == 0.
  localparam int W = BURST_BITS + 1;
  localparam logic [W-1:0] PAGE_WORDS = W'(1 << COL_BITS);
  localparam logic [W-1:0] MAX_LEN    = W'(MAX_BURST_LEN);

  logic [W-1:0] req_ext;
  logic [W-1:0] page_room;
  logic [W-1:0] min_a;
  logic [W-1:0] min_b;

  assign req_ext   = {1'b0, req_len};
  assign page_room = PAGE_WORDS - W'(col);
  assign min_a     = (req_ext < MAX_LEN) ? req_ext : MAX_LEN;
  assign min_b     = (min_a < page_room) ? min_a : page_room;
  // min_b <= MAX_BURST_LEN, which fits in BURST_BITS.
  assign len_eff   = BURST_BITS'(min_b);

endmodule

// File: rtl/wr_burst_bridge.sv
// wr_burst_bridge -- relays a drawing primitive's write burst to the SDRAM
// controller. The request is clipped at the page boundary and at
// MAX_BURST_LEN, so the primitive simply re-requests the remainder starting
// at its own (already advanced) address.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   write_burst_req          primitive burst request (held until finish)
//   addr, write_burst_len    burst start address / requested beats
//   rgb                      pixel for the current beat
//   write_burst_data_req     beat consumed; primitive advances next cycle
//   write_burst_data_finish  one-cycle pulse at burst end
//   busy                     bridge not idle
//   err_short                sticky: controller finished before all beats
//   sdram                    SDRAM controller write port (master side)
module wr_burst_bridge
  import gfx_pkg::*;
#(
  parameter int BURST_BITS    = 10,
  parameter int ADDR_BITS     = ADDR_W,
  parameter int DATA_BITS     = PIXEL_W,
  parameter int COL_BITS      = COL_W,
  parameter int MAX_BURST_LEN = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_burst_req,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [BURST_BITS-1:0] write_burst_len,
  input  logic [DATA_BITS-1:0]  rgb,
  output logic                  write_burst_data_req,
  output logic                  write_burst_data_finish,
  output logic                  busy,
  output logic                  err_short,
  wr_burst_bridge_if.master     sdram
);

  wr_bridge_state_t      state_reg, state_next;
  logic [ADDR_BITS-1:0]  addr_reg, addr_next;
  logic [BURST_BITS-1:0] len_reg, len_next;
  logic [BURST_BITS-1:0] beats_reg, beats_next;
  logic                  err_short_reg, err_short_next;

  logic [BURST_BITS-1:0] len_eff;
  logic                  beat;
  logic [BURST_BITS-1:0] beats_inc;

  burst_len_clip #(
    .BURST_BITS    (BURST_BITS),
    .COL_BITS      (COL_BITS),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_clip (
    .req_len (write_burst_len),
    .col     (addr[COL_BITS-1:0]),
    .len_eff (len_eff)
  );

  // A controller data request becomes a beat only while beats remain;
  // surplus requests are dropped.
  assign beat      = (state_reg == ST_DATA) && sdram.sdram_wr_data_req &&
                     (beats_reg < len_reg);
  assign beats_inc = beats_reg + BURST_BITS'(beat);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      len_reg       <= '0;
      beats_reg     <= '0;
      err_short_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      len_reg       <= len_next;
      beats_reg     <= beats_next;
      err_short_reg <= err_short_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    len_next       = len_reg;
    beats_next     = beats_reg;
    err_short_next = err_short_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (write_burst_req) begin
          addr_next  = addr;
          len_next   = len_eff;
          beats_next = '0;
          state_next = (len_eff == '0) ? ST_FIN : ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram.sdram_wr_ack) state_next = ST_DATA;
      end
      ST_DATA: begin
        beats_next = beats_inc;
        // Judge completion on the count including this cycle's beat, so a
        // done arriving together with the last beat is not an error.
        if (beats_inc == len_reg) begin
          state_next = sdram.sdram_wr_done ? ST_FIN : ST_WAIT_DONE;
        end else if (sdram.sdram_wr_done) begin
          err_short_next = 1'b1;
          state_next     = ST_FIN;
        end
      end
      ST_WAIT_DONE: begin
        if (sdram.sdram_wr_done) state_next = ST_FIN;
      end
      ST_FIN: begin
        // A request still held here is picked up from IDLE next cycle.
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign sdram.sdram_wr_req  = (state_reg == ST_REQ);
  assign sdram.sdram_wr_addr = addr_reg;
  assign sdram.sdram_wr_len  = len_reg;
  assign sdram.sdram_wr_data = (state_reg == ST_DATA) ? rgb : '0;

  assign write_burst_data_req    = beat;
  assign write_burst_data_finish = (state_reg == ST_FIN);
  assign busy                    = (state_reg != ST_IDLE);
  assign err_short               = err_short_reg;

endmodule
